// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types, PTW dmem command encodings and responder state enum
package mmu_pkg;
  localparam int SIZE_VADDR = 39;
  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [4:0] M_XA_OR = 5'b01010;
  localparam logic [3:0] MT_D = 4'b0011;
  typedef struct packed {
    logic valid;
    logic phys;
    logic [4:0] cmd;
    logic [3:0] typ;
    logic [SIZE_VADDR:0] addr;
    logic kill;
    logic [63:0] data;
  } ptw_dmem_comm_t;
  typedef struct packed {
    logic valid;
    logic nack;
    logic [63:0] data;
  } dmem_ptw_resp_t;
  typedef struct packed {
    logic dmem_ready;
    dmem_ptw_resp_t resp;
  } dmem_ptw_comm_t;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RESP, S_NACK} ptw_resp_state_t;
endpackage

// File: rtl/ptw_dmem_responder.sv
// ptw_dmem_responder: runs PTW reads and atomic-OR A/D updates on a single-outstanding memory port (PTW_RESP_TIMEOUT_EN adds a response timeout)
module ptw_dmem_responder
  import mmu_pkg::*;
`ifdef PTW_RESP_TIMEOUT_EN
  #(parameter int MEM_TIMEOUT = 255)
`endif
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  ptw_dmem_comm_t      ptw_dmem_comm_i,
  output dmem_ptw_comm_t      dmem_ptw_comm_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_we_o,
  output logic [SIZE_VADDR:0] mem_req_addr_o,
  output logic [63:0]         mem_req_wdata_o,
  input  logic                mem_resp_valid_i,
  input  logic [63:0]         mem_resp_data_i,
  input  logic                mem_resp_err_i
);
  ptw_resp_state_t state, state_nxt;
  logic [4:0] cmd;
  logic [SIZE_VADDR:0] addr;
  logic [63:0] data, rdata;
  logic accept, legal, timeout;
  assign accept = ptw_dmem_comm_i.valid && state == S_IDLE;
  assign legal = (ptw_dmem_comm_i.cmd == M_XRD || ptw_dmem_comm_i.cmd == M_XA_OR) &&
                 ptw_dmem_comm_i.typ == MT_D && ptw_dmem_comm_i.addr[2:0] == 3'b000 && ptw_dmem_comm_i.phys;
`ifdef PTW_RESP_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  // Cycles spent in the current wait state; back to zero outside, so each entry starts fresh
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) wait_cnt <= '0;
    else wait_cnt <= (state == S_RD_WAIT || state == S_WR_WAIT) ? wait_cnt + 1'b1 : '0;
  assign timeout = wait_cnt == CW'(MEM_TIMEOUT);
`else
  assign timeout = 1'b0;
`endif
  // State register
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= S_IDLE;
    else state <= state_nxt;
  // Request fields held from accept; rdata is the pre-OR word from the read phase
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      cmd <= '0;
      addr <= '0;
      data <= '0;
      rdata <= '0;
    end else begin
      if (accept) begin
        cmd <= ptw_dmem_comm_i.cmd;
        addr <= ptw_dmem_comm_i.addr;
        data <= ptw_dmem_comm_i.data;
      end
      if (state == S_RD_WAIT && mem_resp_valid_i && !mem_resp_err_i) rdata <= mem_resp_data_i;
    end
  // Next state: decode at accept, read, optional OR write-back, then one response cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept && !ptw_dmem_comm_i.kill) state_nxt = legal ? S_RD : S_NACK;
      S_RD:      if (mem_req_ready_i) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_resp_valid_i) state_nxt = mem_resp_err_i ? S_NACK : (cmd == M_XRD ? S_RESP : S_WR);
                 else if (timeout) state_nxt = S_NACK;
      S_WR:      if (mem_req_ready_i) state_nxt = S_WR_WAIT;
      S_WR_WAIT: if (mem_resp_valid_i) state_nxt = mem_resp_err_i ? S_NACK : S_RESP;
                 else if (timeout) state_nxt = S_NACK;
      default:   state_nxt = S_IDLE;
    endcase
  end
  assign dmem_ptw_comm_o = '{dmem_ready: state == S_IDLE,
                             resp: '{valid: state == S_RESP, nack: state == S_NACK,
                                     data: state == S_RESP ? rdata : 64'h0}};
  assign mem_req_valid_o = state == S_RD || state == S_WR;
  assign mem_req_we_o = state == S_WR;
  assign mem_req_addr_o = addr;
  assign mem_req_wdata_o = rdata | data;
endmodule

// File: tb/tb_ptw_dmem_responder.sv
// tb_ptw_dmem_responder: randomized bench with a memory environment and a transaction-level reference model
module tb_ptw_dmem_responder;
  import mmu_pkg::*;
  typedef struct packed {
    logic we;
    logic [SIZE_VADDR:0] addr;
    logic [63:0] wdata;
  } op_t;
  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  ptw_dmem_comm_t req;
  dmem_ptw_comm_t rsp;
  logic mem_req_valid_o, mem_req_we_o;
  logic mem_req_ready_i = 1'b0, mem_resp_valid_i = 1'b0, mem_resp_err_i = 1'b0;
  logic [SIZE_VADDR:0] mem_req_addr_o;
  logic [63:0] mem_req_wdata_o, mem_resp_data_i = 64'h0;
  int n_chk = 0, n_pass = 0;
  op_t ops[$];
  logic [63:0] env_mem [32];
  logic [63:0] ref_mem [32];
  int d_rdy = 0, r_dly = 0;
  bit err_rd = 0, err_wr = 0, no_resp = 0, stray_en = 0, addr_bad = 0;
  always #5 clk = ~clk;
`ifdef PTW_RESP_TIMEOUT_EN
  ptw_dmem_responder #(.MEM_TIMEOUT(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .ptw_dmem_comm_i(req), .dmem_ptw_comm_o(rsp),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i));
`else
  ptw_dmem_responder dut (
    .clk_i(clk), .rstn_i(rstn_i), .ptw_dmem_comm_i(req), .dmem_ptw_comm_o(rsp),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i));
`endif
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // Memory environment: delayed ready, delayed response, error injection, stray responses
  initial begin
    int pend, wc, rc;
    bit seen, perr;
    logic [63:0] pdata;
    logic [SIZE_VADDR:0] a0;
    pend = 0; wc = 0; rc = 0; seen = 0; perr = 0; pdata = '0; a0 = '0;
    forever begin
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_err_i = 1'b0;
      mem_resp_data_i = '0;
      if (!rstn_i) begin
        pend = 0;
        seen = 0;
      end else if (pend != 0) begin
        if (rc == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_err_i = perr;
          mem_resp_data_i = pdata;
          pend = 0;
        end else rc--;
      end else if (mem_req_valid_o) begin
        if (!seen) begin
          seen = 1;
          a0 = mem_req_addr_o;
          wc = d_rdy;
        end else if (mem_req_addr_o != a0) addr_bad = 1;
        if (wc == 0) begin
          mem_req_ready_i = 1'b1;
          seen = 0;
          ops.push_back(op_t'{we: mem_req_we_o, addr: mem_req_addr_o, wdata: mem_req_wdata_o});
          perr = mem_req_we_o ? err_wr : err_rd;
          pdata = mem_req_we_o ? {$urandom, $urandom} : env_mem[mem_req_addr_o[7:3]];
          if (mem_req_we_o && !perr) env_mem[mem_req_addr_o[7:3]] = mem_req_wdata_o;
          pend = no_resp ? 0 : 1;
          rc = r_dly;
        end else wc--;
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_err_i = 1'($urandom_range(0, 1));
        mem_resp_data_i = {$urandom, $urandom};
      end
    end
  end
  // One PTW request: reference outcome from the request rules, then drive and compare
  task automatic txn(input logic [4:0] cmd, input logic [3:0] typ, input logic [SIZE_VADDR:0] addr,
                     input logic phys, input logic kill, input logic [63:0] data, input bit hold,
                     output logic [63:0] got);
    bit legal, rdy_all;
    int exp_kind, exp_lat, kind, lat, lim;
    logic [63:0] exp_data, old;
    op_t exp_ops[$];
    legal = (cmd == M_XRD || cmd == M_XA_OR) && typ == MT_D && addr[2:0] == 3'b000 && phys;
    exp_kind = 0; exp_lat = 0; exp_data = '0;
    if (!kill) begin
      if (!legal) begin
        exp_kind = 2;
        exp_lat = 1;
      end else begin
        old = ref_mem[addr[7:3]];
        exp_ops.push_back(op_t'{we: 1'b0, addr: addr, wdata: 64'h0});
        if (err_rd) begin
          exp_kind = 2;
          exp_lat = 3 + d_rdy + r_dly;
        end else if (cmd == M_XRD) begin
          exp_kind = 1;
          exp_lat = 3 + d_rdy + r_dly;
          exp_data = old;
        end else begin
          exp_ops.push_back(op_t'{we: 1'b1, addr: addr, wdata: old | data});
          exp_kind = err_wr ? 2 : 1;
          exp_lat = 5 + 2 * (d_rdy + r_dly);
          exp_data = err_wr ? 64'h0 : old;
          if (!err_wr) ref_mem[addr[7:3]] = old | data;
        end
      end
    end
    ops.delete();
    @(negedge clk);
    check("ready_before", 64'(rsp.dmem_ready), 64'd1);
    req.valid = 1'b1; req.phys = phys; req.cmd = cmd; req.typ = typ;
    req.addr = addr; req.kill = kill; req.data = data;
    kind = 0; lat = 0; got = '0; rdy_all = 1;
    lim = kill ? 6 : 60;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      rdy_all &= rsp.dmem_ready;
      if (rsp.resp.valid || rsp.resp.nack) begin
        kind = (rsp.resp.valid && rsp.resp.nack) ? 3 : (rsp.resp.valid ? 1 : 2);
        lat = c;
        got = rsp.resp.data;
        req.valid = 1'b0;
        break;
      end
      if (c == 1) begin
        req.valid = hold && !kill;
        req.cmd = 5'($urandom); req.typ = 4'($urandom); req.phys = 1'($urandom);
        req.addr = (SIZE_VADDR+1)'({$urandom, $urandom}); req.data = {$urandom, $urandom};
        req.kill = 1'b0;
      end
    end
    if (kill) check("kill_ready", 64'(rdy_all), 64'd1);
    check("resp_kind", 64'(kind), 64'(exp_kind));
    if (exp_kind != 0) check("resp_lat", 64'(lat), 64'(exp_lat));
    check("resp_data", got, exp_data);
    check("op_count", 64'(ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < ops.size() && i < exp_ops.size(); i++) begin
      check("op_we", 64'(ops[i].we), 64'(exp_ops[i].we));
      check("op_addr", 64'(ops[i].addr), 64'(exp_ops[i].addr));
      if (exp_ops[i].we) check("op_wdata", ops[i].wdata, exp_ops[i].wdata);
    end
    @(negedge clk);
    check("resp_pulse", 64'({rsp.resp.valid, rsp.resp.nack, rsp.dmem_ready}), 64'd1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({rsp.dmem_ready, rsp.resp.valid, rsp.resp.nack, mem_req_valid_o, mem_req_we_o}), 64'b10000);
    check({tag, "_data"}, rsp.resp.data | 64'(mem_req_addr_o) | mem_req_wdata_o, 64'h0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    logic [63:0] got;
    bit seen_resp;
    int lat, cmd_sel, misa;
    for (int i = 0; i < 32; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    req = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    env_mem[0] = 64'h0000_0000_2000_0401; ref_mem[0] = env_mem[0];
    txn(M_XRD, MT_D, 'h1000, 1'b1, 1'b0, 64'h0, 1'b0, got);
    check("rd_literal", got, 64'h0000_0000_2000_0401);
    env_mem[1] = 64'h2000_0001; ref_mem[1] = env_mem[1];
    txn(M_XA_OR, MT_D, 'h1008, 1'b1, 1'b0, 64'hC0, 1'b0, got);
    check("or_literal", got, 64'h2000_0001);
    check("or_mem", env_mem[1], 64'h2000_00C1);
    txn(5'b00001, MT_D, 'h1000, 1'b1, 1'b0, 64'h0, 1'b0, got);
    txn(M_XRD, MT_D, 'h1004, 1'b1, 1'b0, 64'h0, 1'b0, got);
    txn(M_XRD, 4'b0010, 'h1000, 1'b1, 1'b0, 64'h0, 1'b0, got);
    txn(M_XRD, MT_D, 'h1000, 1'b0, 1'b0, 64'h0, 1'b0, got);
    d_rdy = 4; err_rd = 1; addr_bad = 0;
    txn(M_XRD, MT_D, 'h1010, 1'b1, 1'b0, 64'h0, 1'b0, got);
    check("addr_stable", 64'(addr_bad), 64'd0);
    d_rdy = 0; err_rd = 0;
    txn(M_XA_OR, MT_D, 'h1018, 1'b1, 1'b1, 64'h1, 1'b0, got);
    // Reset while the OR write-back is outstanding
    ops.delete(); r_dly = 6;
    @(negedge clk);
    req.valid = 1'b1; req.phys = 1'b1; req.cmd = M_XA_OR; req.typ = MT_D;
    req.addr = 'h1018; req.kill = 1'b0; req.data = 64'h5;
    @(negedge clk);
    req.valid = 1'b0;
    for (int c = 0; c < 40 && ops.size() < 2; c++) @(negedge clk);
    check("rst_ops", 64'(ops.size()), 64'd2);
    ref_mem[3] = ref_mem[3] | 64'h5;
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    r_dly = 0;
    seen_resp = 0;
    repeat (10) begin
      @(negedge clk);
      seen_resp |= rsp.resp.valid | rsp.resp.nack | ~rsp.dmem_ready;
    end
    check("post_reset_quiet", 64'(seen_resp), 64'd0);
    for (int t = 0; t < 200; t++) begin
      cmd_sel = $urandom_range(0, 9);
      misa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      d_rdy = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      err_rd = $urandom_range(0, 9) == 0;
      err_wr = $urandom_range(0, 9) == 0;
      stray_en = 1'($urandom_range(0, 1));
      txn(cmd_sel < 4 ? M_XRD : (cmd_sel < 8 ? M_XA_OR : 5'($urandom)),
          $urandom_range(0, 9) == 0 ? 4'($urandom) : MT_D,
          (SIZE_VADDR+1)'('h1000 + 8 * $urandom_range(0, 31) + misa),
          1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0),
          64'(1) << $urandom_range(0, 63), 1'($urandom_range(0, 1)), got);
    end
    err_rd = 0; err_wr = 0; stray_en = 0; d_rdy = 0; r_dly = 0;
`ifdef PTW_RESP_TIMEOUT_EN
    no_resp = 1;
    @(negedge clk);
    req.valid = 1'b1; req.phys = 1'b1; req.cmd = M_XRD; req.typ = MT_D;
    req.addr = 'h1000; req.kill = 1'b0; req.data = 64'h0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req.valid = 1'b0;
      if (rsp.resp.nack) begin
        lat = c;
        break;
      end
    end
    check("timeout_lat", 64'(lat), 64'd11);
    stray_en = 1;
    seen_resp = 0;
    repeat (10) begin
      @(negedge clk);
      seen_resp |= rsp.resp.valid | rsp.resp.nack;
    end
    check("late_resp_ignored", 64'(seen_resp), 64'd0);
    no_resp = 0; stray_en = 0;
`else
    lat = 0;
`endif
    lat = 0;
    for (int i = 0; i < 32; i++) if (env_mem[i] !== ref_mem[i]) lat++;
    check("final_mem", 64'(lat), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ptw_dmem_responder.md
# ptw_dmem_responder

Memory-side responder for the page-table walker's dmem port. It accepts PTW requests over the `ptw_dmem_comm_t`/`dmem_ptw_comm_t` handshake and executes them against a simple single-outstanding memory port. Supported requests are 64-bit reads (`M_XRD`) and atomic OR read-modify-writes (`M_XA_OR`, used to set A/D bits). It returns one `resp.valid` with the old memory word, or one `resp.nack`. It sits between `ptw` and the L1/system memory interface in the MMU subsystem.

## Interface
- `MEM_TIMEOUT`, 255: cycles to wait for `mem_resp_valid_i` before nacking; only used with `PTW_RESP_TIMEOUT_EN`.
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `ptw_dmem_comm_i` in `ptw_dmem_comm_t`: PTW request.
  - Fields: `valid`, `phys`, `cmd[4:0]`, `typ[3:0]`, `addr[SIZE_VADDR:0]`, `kill`, `data[63:0]`.
- `dmem_ptw_comm_o` out `dmem_ptw_comm_t`: response.
  - Fields: `dmem_ready`, `resp.valid`, `resp.nack`, `resp.data[63:0]`.
- `mem_req_valid_o` out 1: memory request valid.
- `mem_req_ready_i` in 1: memory accepts the request this cycle.
- `mem_req_we_o` out 1: 1 means write, 0 means read.
- `mem_req_addr_o` out SIZE_VADDR+1: physical byte address, 8-byte aligned.
- `mem_req_wdata_o` out 64: write data.
- `mem_resp_valid_i` in 1: read data valid, or write acknowledge.
- `mem_resp_data_i` in 64: read data.
- `mem_resp_err_i` in 1: bus error; qualified by `mem_resp_valid_i`.

## Operation
**States:** S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RESP, S_NACK.

**Handshake and accept**
- `dmem_ready` = (state == S_IDLE). A request is accepted when `req.valid && dmem_ready`.
- On accept, latch `cmd`, `addr`, `data`.

**Decode at accept**
- `kill`=1: drop the request. Stay in S_IDLE, no memory access, no response.
- Nack with no memory access (go to S_NACK) if any of:
  - `cmd` is not `M_XRD` (5'b00000) and not `M_XA_OR` (5'b01010);
  - `typ` != `MT_D` (4'b0011);
  - `addr[2:0]` != 0;
  - `phys` = 0.
- Otherwise go to S_RD.

**Read phase**
- S_RD: `mem_req_valid_o`=1, `we`=0. On `mem_req_ready_i`, go to S_RD_WAIT.
- S_RD_WAIT: on `mem_resp_valid_i`:
  - `mem_resp_err_i` → S_NACK;
  - else latch `rdata` = `mem_resp_data_i`; `M_XRD` → S_RESP, `M_XA_OR` → S_WR.

**Write phase (`M_XA_OR` only)**
- S_WR: `mem_req_valid_o`=1, `we`=1, `wdata` = `rdata` | latched `data`. On ready, go to S_WR_WAIT.
- S_WR_WAIT: on `mem_resp_valid_i`, `err` → S_NACK, else → S_RESP.
- Response data is always the pre-OR value.

**Response**
- S_RESP: `resp.valid`=1 and `resp.data` = `rdata` for exactly one cycle, then S_IDLE.
- S_NACK: `resp.nack`=1 for exactly one cycle, then S_IDLE. `resp.valid` stays 0 and `resp.data` = 0.

**Address and atomicity**
- `mem_req_addr_o` = latched `addr`, unchanged.
- Read and write of one `M_XA_OR` are never separated by another request, because only one request is outstanding at a time.

**Boundary conditions**
- `mem_resp_valid_i` outside S_RD_WAIT/S_WR_WAIT is ignored.
- `req.valid` while busy is ignored (`dmem_ready`=0); the PTW holds or retries.
- Reset mid-operation: return to S_IDLE. Any in-flight memory transaction is abandoned and no response is issued.

## Timing
- Reset values: `dmem_ready`=1, `resp.valid`=0, `resp.nack`=0, `resp.data`=0, `mem_req_valid_o`=0, `mem_req_we_o`=0, `mem_req_addr_o`=0, `mem_req_wdata_o`=0.
- Memory-port outputs are driven from registered state only, so there is no combinational path from `mem_*` inputs to `mem_req_*` outputs.
- Read, request accepted at cycle N with zero-wait memory:
  - N+1: S_RD with `mem_req_valid_o`; `ready` sampled.
  - N+2: S_RD_WAIT; `mem_resp_valid_i` arrives.
  - N+3: `resp.valid`.
  - Minimum latency is 3 cycles.
- `M_XA_OR` minimum latency: 5 cycles.
- Nack on decode failure: `resp.nack` at N+1.
- Back-to-back: the next accept is possible the cycle after S_RESP/S_NACK.

## Configuration
- `PTW_RESP_TIMEOUT_EN` defined:
  - A counter clears on entry to S_RD_WAIT/S_WR_WAIT and increments each cycle in those states.
  - When it reaches `MEM_TIMEOUT` with no `mem_resp_valid_i`, go to S_NACK.
  - A late response is then ignored.
- Undefined: no counter; the block waits indefinitely in the wait states.

## Structure
- `mmu_pkg` holds:
  - `M_XRD`, `M_XA_OR`, `MT_D` (currently local to the walker; move them to the package);
  - the state enum `ptw_resp_state_t`.
- `ptw_dmem_comm_t` and `dmem_ptw_comm_t` stay in `mmu_pkg` unchanged.
- Single module; no sub-module.

## Test plan
- Read, memory[0x1000]=0x0000_0000_2000_0401, zero-wait → `resp.valid` at N+3 with data 0x2000_0401; exactly one `mem` read.
- `M_XA_OR` at 0x1008, mem=0x2000_0001, `data`=0xC0 → write 0x2000_00C1 to 0x1008; response data 0x2000_0001; valid at N+5.
- `cmd`=5'b00001 or `addr`=0x1004 → `resp.nack` at N+1; `mem_req_valid_o` never asserted.
- `mem_req_ready_i` held low 4 cycles, then `mem_resp_err_i`=1 on response → address stable throughout; `resp.nack` one cycle later.
- `kill`=1 at accept → no response, no mem access, `dmem_ready` stays 1. Also: `rstn_i` low during S_WR_WAIT → all outputs at reset values, S_IDLE.
- With `PTW_RESP_TIMEOUT_EN`, `MEM_TIMEOUT`=8, no memory response → `resp.nack` 9 cycles after entering S_RD_WAIT; a later `mem_resp_valid_i` is ignored.
